// File: rtl/tc_program_loader.sv
// Program-memory loader: consumes a length/data/checksum framed byte stream and
// drives a byte-wide memory write port, holding the CPU in reset until a frame loads cleanly.
module tc_program_loader #(
    parameter int MEM_BYTES = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       byte_count
);

    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR
    } state_t;

    localparam logic [16:0] MEM_LIMIT = 17'(MEM_BYTES);

    state_t      state;
    logic [15:0] len;
    logic [7:0]  sum;
    logic        xfer;
    logic [15:0] len_full;
    logic [15:0] count_next;

    assign xfer       = in_valid && in_ready;
    assign len_full   = {in_data, len[7:0]};
    assign count_next = byte_count + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            len        <= '0;
            sum        <= '0;
            in_ready   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cpu_hold   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            byte_count <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state      <= LEN_LO;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                        cpu_hold   <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        byte_count <= '0;
                        sum        <= '0;
                        wr_addr    <= '0;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len[7:0] <= in_data;
                        state    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len <= len_full;
                        if ({1'b0, len_full} > MEM_LIMIT) begin
                            state    <= ERR;
                            error    <= 1'b1;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                        end else if (len_full == 16'd0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    // Address comes from the pre-increment count so writes start at 0.
                    if (xfer) begin
                        wr_en      <= 1'b1;
                        wr_data    <= in_data;
                        wr_addr    <= byte_count[ADDR_W-1:0];
                        byte_count <= count_next;
                        sum        <= sum + in_data;
                        if (count_next == len)
                            state <= CSUM;
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (in_data == sum) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
